div_unit: RTL and testbench

//   Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.

---
 rtl/div_unit.sv | 177 +++++++++++++++++
 tb/tb_div_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional build macro: DIV_EARLY_OUT_EN (skip CALC for trivially resolved ops).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] dvsr_reg, dvsr_next;
    logic [WIDTH-1:0] dvnd_reg, dvnd_next;
    logic             sel_rem_reg, sel_rem_next;
    logic             q_neg_reg, q_neg_next;
    logic             r_neg_reg, r_neg_next;
    logic             dz_reg, dz_next;
    logic             ovf_reg, ovf_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] result_reg, result_next;

    logic             is_signed, a_neg, b_neg, start_dz, start_ovf, early;
    logic [WIDTH-1:0] abs_a, abs_b, q_final, r_final;
    logic [WIDTH:0]   shifted, trial;
    logic             unused_ok;

    assign is_signed = ~funct3[0];
    assign a_neg     = is_signed & dividend[WIDTH-1];
    assign b_neg     = is_signed & divisor[WIDTH-1];
    assign abs_a     = a_neg ? -dividend : dividend;
    assign abs_b     = b_neg ? -divisor : divisor;
    assign start_dz  = (divisor == '0);
    assign start_ovf = is_signed && (dividend == MIN_NEG) && (divisor == '1);

`ifdef DIV_EARLY_OUT_EN
    assign early = start_dz | start_ovf | (abs_b > abs_a);
`else
    assign early = 1'b0;
`endif

    // Shift in the next dividend bit (MSB of the quotient shift register).
    assign shifted = {rem_reg, quo_reg[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvsr_reg};

    assign q_final = dz_reg  ? '1 :
                     ovf_reg ? MIN_NEG :
                     (q_neg_reg ? -quo_reg : quo_reg);
    assign r_final = dz_reg  ? dvnd_reg :
                     ovf_reg ? '0 :
                     (r_neg_reg ? -rem_reg : rem_reg);

    assign unused_ok = ^{funct3[2], trial[WIDTH]};

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        dvsr_next    = dvsr_reg;
        dvnd_next    = dvnd_reg;
        sel_rem_next = sel_rem_reg;
        q_neg_next   = q_neg_reg;
        r_neg_next   = r_neg_reg;
        dz_next      = dz_reg;
        ovf_next     = ovf_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        result_next  = result_reg;
        case (state_reg)
            IDLE: begin
                if (start && !flush) begin
                    dvsr_next    = abs_b;
                    dvnd_next    = dividend;
                    sel_rem_next = funct3[1];
                    q_neg_next   = a_neg ^ b_neg;
                    r_neg_next   = a_neg;
                    dz_next      = start_dz;
                    ovf_next     = start_ovf;
                    count_next   = CW'(WIDTH - 1);
                    busy_next    = 1'b1;
                    // Early-out leaves quotient 0 and remainder |dividend|.
                    if (early) begin
                        quo_next   = '0;
                        rem_next   = abs_a;
                        state_next = FIX;
                    end else begin
                        quo_next   = abs_a;
                        rem_next   = '0;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else begin
                    if (shifted >= {1'b0, dvsr_reg}) begin
                        rem_next = trial[WIDTH-1:0];
                        quo_next = {quo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_next = shifted[WIDTH-1:0];
                        quo_next = {quo_reg[WIDTH-2:0], 1'b0};
                    end
                    count_next = count_reg - 1'b1;
                    if (count_reg == '0)
                        state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                if (!flush) begin
                    done_next   = 1'b1;
                    result_next = sel_rem_reg ? r_final : q_final;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvsr_reg    <= '0;
            dvnd_reg    <= '0;
            sel_rem_reg <= 1'b0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            dz_reg      <= 1'b0;
            ovf_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            dvsr_reg    <= dvsr_next;
            dvnd_reg    <= dvnd_next;
            sel_rem_reg <= sel_rem_next;
            q_neg_reg   <= q_neg_next;
            r_neg_reg   <= r_neg_next;
            dz_reg      <= dz_next;
            ovf_reg     <= ovf_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            result_reg  <= result_next;
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, latency, DONE pulse, START-while-busy, FLUSH and reset.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .funct3(funct3), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one op, wait (bounded) for DONE, check result, latency and pulse width.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit is_early);
        int cyc;
        int lat;
        logic [31:0] got;
        lat = 33;
`ifdef DIV_EARLY_OUT_EN
        if (is_early) lat = 1;
`else
        if (is_early) lat = 33;
`endif
        @(negedge clk);
        start = 1'b1; funct3 = f3; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0003;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        got = result;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_lat"}, cyc, lat);
        check({tag, "_res"}, got, exp);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, result, got);
        $display("[TB] %s f3=%b a=%h b=%h result=%h cycles=%0d", tag, f3, a, b, got, cyc);
    endtask

    initial begin
        int seen;
        logic [31:0] prev;
        reset = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'b000;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk); reset = 1'b1;

        do_op("divu_100_7",  3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
        do_op("remu_100_7",  3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
        do_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        do_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        do_op("div_7_m2",    3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        do_op("rem_7_m2",    3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        do_op("div_x_0",     3'b100, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b1);
        do_op("rem_x_0",     3'b110, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1);
        do_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        do_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
        do_op("divu_3_9",    3'b101, 32'd3, 32'd9, 32'd0, 1'b1);
        do_op("remu_3_9",    3'b111, 32'd3, 32'd9, 32'd3, 1'b1);
        do_op("divu_max_1",  3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
        do_op("remu_max_16", 3'b111, 32'hFFFF_FFFF, 32'd16, 32'd15, 1'b0);
        do_op("divu_min_3",  3'b101, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 1'b0);

        // START while busy is ignored, FLUSH aborts with no DONE and RESULT kept.
        prev = result;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        check("busy_start_ignored", {31'd0, busy}, 32'd1);
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("flush_no_done", seen, 0);
        check("flush_result_kept", result, prev);
        $display("[TB] flush_op result=%h done_seen=%0d", result, seen);

        // Reset in the middle of an op clears outputs immediately.
        do_op("divu_after_flush", 3'b101, 32'd1000, 32'd10, 32'd100, 1'b0);
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; dividend = 32'd77; divisor = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        @(negedge clk); reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("midrst_no_done", seen, 0);
        $display("[TB] midop_reset result=%h done_seen=%0d", result, seen);

        do_op("rem_after_rst", 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
